// File: rtl/ysyx_23060184_sram_read_slave.sv
// AXI4-lite read responder backed by a word-addressed SRAM with a backdoor write port.
// Define SRAM_RAND_DELAY_EN to add 0..7 LFSR-driven cycles to each response latency.
module ysyx_23060184_sram_read_slave #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ACERR_WIDTH  = 2,
    parameter int                    DEPTH        = 4096,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h8000_0000,
    parameter int                    READ_LATENCY = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [DATA_WIDTH-1:0]  araddr_i,
    input  logic                   arvalid_i,
    output logic                   arready_o,
    output logic [DATA_WIDTH-1:0]  rdata_o,
    output logic [ACERR_WIDTH-1:0] rresp_o,
    output logic                   rvalid_o,
    input  logic                   rready_i,
    input  logic                   init_we_i,
    input  logic [DATA_WIDTH-1:0]  init_addr_i,
    input  logic [DATA_WIDTH-1:0]  init_data_i
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [DATA_WIDTH:0] END_ADDR =
        {1'b0, BASE_ADDR} + (DATA_WIDTH+1)'(4 * DEPTH);
    localparam logic [ACERR_WIDTH-1:0] RESP_OKAY   = ACERR_WIDTH'(2'b00);
    localparam logic [ACERR_WIDTH-1:0] RESP_SLVERR = ACERR_WIDTH'(2'b10);
    localparam logic [ACERR_WIDTH-1:0] RESP_DECERR = ACERR_WIDTH'(2'b11);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state_q;
    logic [4:0]              cnt_q;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic                    rvalid_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [ACERR_WIDTH-1:0]  rresp_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [4:0]              lat_load;
    logic [DATA_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rsp_data_d;
    logic [ACERR_WIDTH-1:0]  rsp_code_d;

    function automatic logic in_range(input logic [DATA_WIDTH-1:0] a);
        return (a >= BASE_ADDR) && ({1'b0, a} < END_ADDR);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [DATA_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

`ifdef SRAM_RAND_DELAY_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) lfsr_q <= 8'hA5;
        else         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    assign lat_load = 5'(READ_LATENCY) + {2'b00, lfsr_q[2:0]};
`else
    assign lat_load = 5'(READ_LATENCY);
`endif

    // Zero-latency requests respond straight from the bus address on the handshake edge.
    assign rd_addr = (state_q == S_IDLE) ? araddr_i : addr_q;

    always_comb begin
        rsp_data_d = '0;
        rsp_code_d = RESP_OKAY;
        if (!in_range(rd_addr)) begin
            rsp_code_d = RESP_DECERR;
        end else if (rd_addr[1:0] != 2'b00) begin
            rsp_code_d = RESP_SLVERR;
        end else begin
            rsp_data_d = mem_q[word_idx(rd_addr)];
        end
    end

    assign arready_o = (state_q == S_IDLE) && !reset_i;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;

    always_ff @(posedge clk_i) begin
        if (init_we_i && in_range(init_addr_i) && (init_addr_i[1:0] == 2'b00)) begin
            mem_q[word_idx(init_addr_i)] <= init_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arvalid_i) begin
                        addr_q <= araddr_i;
                        cnt_q  <= lat_load;
                        if (lat_load != 5'd0) begin
                            state_q <= S_WAIT;
                        end else begin
                            state_q  <= S_RESP;
                            rvalid_q <= 1'b1;
                            rdata_q  <= rsp_data_d;
                            rresp_q  <= rsp_code_d;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_q  <= S_RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= rsp_data_d;
                        rresp_q  <= rsp_code_d;
                    end
                end
                S_RESP: begin
                    if (rready_i) begin
                        state_q  <= S_IDLE;
                        rvalid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060184_sram_read_slave.sv
// Directed bench for ysyx_23060184_sram_read_slave: vector table plus hand-written
// sequences for stall, backdoor collision and mid-transaction reset.
module tb_ysyx_23060184_sram_read_slave;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        init_we;
    logic [31:0] init_addr;
    logic [31:0] init_data;

    int total = 0;
    int bad   = 0;

    ysyx_23060184_sram_read_slave #(
        .DATA_WIDTH(32), .ACERR_WIDTH(2), .DEPTH(4096),
        .BASE_ADDR(32'h8000_0000), .READ_LATENCY(LAT)
    ) dut (
        .clk_i(clk), .reset_i(reset), .araddr_i(araddr), .arvalid_i(arvalid),
        .arready_o(arready), .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid),
        .rready_i(rready), .init_we_i(init_we), .init_addr_i(init_addr),
        .init_data_i(init_data)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        init_we = 1'b1; init_addr = a; init_data = d;
        @(negedge clk);
        init_we = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input int stall,
                           output logic [31:0] d, output logic [1:0] r, output int lat);
        @(negedge clk);
        chk("arready_pre", {31'b0, arready}, 32'd1);
        araddr = a; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; araddr = ~a;
        lat = 0;
        while (!rvalid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        d = rdata; r = rresp;
        chk("arready_in_resp", {31'b0, arready}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_rvalid", {31'b0, rvalid}, 32'd1);
            chk("stall_rdata", rdata, d);
            chk("stall_rresp", {30'b0, rresp}, {30'b0, r});
            chk("stall_arready", {31'b0, arready}, 32'd0);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("rvalid_drop", {31'b0, rvalid}, 32'd0);
        chk("arready_back", {31'b0, arready}, 32'd1);
    endtask

    logic [31:0] d;
    logic [1:0]  r;
    int          lat;

    initial begin
        vecs[0] = '{32'h8000_0010, 32'hDEAD_BEEF, 2'b00};
        vecs[1] = '{32'h8000_0000, 32'h1111_1111, 2'b00};
        vecs[2] = '{32'h8000_3FFC, 32'hCAFE_F00D, 2'b00};
        vecs[3] = '{32'h8000_4000, 32'h0,         2'b11};
        vecs[4] = '{32'h7FFF_FFFC, 32'h0,         2'b11};
        vecs[5] = '{32'h8000_0002, 32'h0,         2'b10};
        vecs[6] = '{32'h8000_0001, 32'h0,         2'b10};
        vecs[7] = '{32'h8000_4001, 32'h0,         2'b11};
        vecs[8] = '{32'hFFFF_FFFC, 32'h0,         2'b11};
        vecs[9] = '{32'h0000_0000, 32'h0,         2'b11};

        reset = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        init_we = 1'b0; init_addr = '0; init_data = '0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_arready", {31'b0, arready}, 32'd0);
            chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_rresp", {30'b0, rresp}, 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("arready_after_rst", {31'b0, arready}, 32'd1);

        bd_write(32'h8000_0000, 32'h1111_1111);
        bd_write(32'h8000_0010, 32'hDEAD_BEEF);
        bd_write(32'h8000_0020, 32'h1234_5678);
        bd_write(32'h8000_3FFC, 32'hCAFE_F00D);
        // Illegal backdoor addresses that would alias onto the words above if not ignored.
        bd_write(32'h8000_0012, 32'hBAD0_0001);
        bd_write(32'h8000_4000, 32'hBAD0_0002);
        bd_write(32'h7FFF_FFFC, 32'hBAD0_0003);

        for (int i = 0; i < 10; i++) begin
            do_read(vecs[i].addr, 0, d, r, lat);
            chk($sformatf("vec%0d_rdata", i), d, vecs[i].data);
            chk($sformatf("vec%0d_rresp", i), {30'b0, r}, {30'b0, vecs[i].resp});
            chk($sformatf("vec%0d_lat", i), lat, LAT);
        end

        do_read(32'h8000_0010, 5, d, r, lat);
        chk("stall_data", d, 32'hDEAD_BEEF);

        // Backdoor write landing on the edge that enters RESP must not be seen.
        @(negedge clk);
        araddr = 32'h8000_0020; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        init_we = 1'b1; init_addr = 32'h8000_0020; init_data = 32'hA5A5_5A5A;
        @(negedge clk);
        init_we = 1'b0;
        chk("coll_rvalid", {31'b0, rvalid}, 32'd1);
        chk("coll_old_data", rdata, 32'h1234_5678);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        do_read(32'h8000_0020, 0, d, r, lat);
        chk("coll_new_data", d, 32'hA5A5_5A5A);

        // Reset one cycle into WAIT discards the request.
        @(negedge clk);
        araddr = 32'h8000_0010; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_arready", {31'b0, arready}, 32'd0);
        chk("midrst_rvalid", {31'b0, rvalid}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_resp", {31'b0, rvalid}, 32'd0);
        end
        do_read(32'h8000_0000, 0, d, r, lat);
        chk("postrst_data", d, 32'h1111_1111);
        chk("postrst_resp", {30'b0, r}, 32'd0);
        chk("postrst_lat", lat, LAT);

`ifdef SRAM_RAND_DELAY_EN
        begin
            logic [15:0] seen;
            int          n_seen;
            seen = '0;
            for (int i = 0; i < 100; i++) begin
                do_read(vecs[i % 3].addr, 0, d, r, lat);
                chk("rand_data", d, vecs[i % 3].data);
                chk("rand_lat_range", {31'b0, (lat >= LAT) && (lat <= LAT + 7)}, 32'd1);
                if (lat < 16) seen[lat] = 1'b1;
            end
            n_seen = $countones(seen);
            chk("rand_distinct", {31'b0, n_seen >= 4}, 32'd1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
